imem_loader: RTL

//  Boot-time writer for the instruction memory: receives a byte stream (valid/ready), assembles big-endian
//  32-bit words and drives the memory write port at sequential word addresses 0..N-1.

---
 rtl/imem_loader.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/imem_loader.sv
// Boot-time instruction memory loader: turns a length-prefixed, XOR-checksummed byte stream
// into big-endian 32-bit words written at word addresses 0..N-1, holding the CPU meanwhile.
module imem_loader #(
    parameter int DEPTH = 256,
    parameter int CNT_W = 9
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic [7:0]       i_rx_data,
    input  logic             i_rx_valid,
    output logic             o_rx_ready,
    output logic             o_mem_we,
    output logic [31:0]      o_mem_addr,
    output logic [31:0]      o_mem_wdata,
    output logic             o_busy,
    output logic             o_cpu_hold,
    output logic             o_done,
    output logic             o_err,
    output logic [CNT_W-1:0] o_words_loaded
);

    // state  | meaning
    // IDLE   | waiting for start; done/err hold the last result
    // LEN_HI | expecting word-count high byte
    // LEN_LO | expecting word-count low byte; rejects N > DEPTH
    // DATA   | collecting the 4 bytes of the current word
    // WRITE  | one-cycle memory write strobe
    // CHK    | expecting the XOR checksum byte
    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN_HI,
        S_LEN_LO,
        S_DATA,
        S_WRITE,
        S_CHK
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [15:0]      r_len;
    logic [23:0]      r_word;
    logic [1:0]       r_byte_cnt;
    logic [CNT_W-1:0] r_index;
    logic [7:0]       r_chk;
    logic             r_done;
    logic             r_err;
    logic [CNT_W-1:0] r_words;
    logic [CNT_W-1:0] r_mem_addr;
    logic [31:0]      r_mem_wdata;

    logic             w_accept;
    logic [15:0]      w_len_full;
    logic             w_len_bad;
    logic             w_last;

    assign w_accept   = i_rx_valid && o_rx_ready;
    assign w_len_full = {r_len[15:8], i_rx_data};
    assign w_len_bad  = (w_len_full > 16'(DEPTH));
    assign w_last     = (16'(r_index) == (r_len - 16'd1));

    always_comb begin
        w_next     = r_state;
        o_rx_ready = 1'b0;
        o_mem_we   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_start) w_next = S_LEN_HI;
            end
            S_LEN_HI: begin
                o_rx_ready = 1'b1;
                if (w_accept) w_next = S_LEN_LO;
            end
            S_LEN_LO: begin
                o_rx_ready = 1'b1;
                if (w_accept) begin
                    if (w_len_bad)                w_next = S_IDLE;
                    else if (w_len_full == 16'd0) w_next = S_CHK;
                    else                          w_next = S_DATA;
                end
            end
            S_DATA: begin
                o_rx_ready = 1'b1;
                if (w_accept && (r_byte_cnt == 2'd3)) w_next = S_WRITE;
            end
            S_WRITE: begin
                o_mem_we = 1'b1;
                w_next   = w_last ? S_CHK : S_DATA;
            end
            S_CHK: begin
                o_rx_ready = 1'b1;
                if (w_accept) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= S_IDLE;
            r_len       <= '0;
            r_word      <= '0;
            r_byte_cnt  <= '0;
            r_index     <= '0;
            r_chk       <= '0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_words     <= '0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
        end else begin
            r_state <= w_next;
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_done     <= 1'b0;
                        r_err      <= 1'b0;
                        r_words    <= '0;
                        r_chk      <= '0;
                        r_index    <= '0;
                        r_byte_cnt <= '0;
                    end
                end
                S_LEN_HI: begin
                    if (w_accept) r_len[15:8] <= i_rx_data;
                end
                S_LEN_LO: begin
                    if (w_accept) begin
                        r_len[7:0] <= i_rx_data;
                        if (w_len_bad) r_err <= 1'b1;
                    end
                end
                S_DATA: begin
                    if (w_accept) begin
                        r_word     <= {r_word[15:0], i_rx_data};
                        r_chk      <= r_chk ^ i_rx_data;
                        r_byte_cnt <= r_byte_cnt + 2'd1;
                        // Address/data are latched here so they are valid during the WRITE strobe
                        // and keep the last written values afterwards.
                        if (r_byte_cnt == 2'd3) begin
                            r_mem_addr  <= r_index;
                            r_mem_wdata <= {r_word, i_rx_data};
                        end
                    end
                end
                S_WRITE: begin
                    r_words <= r_words + 1'b1;
                    if (!w_last) r_index <= r_index + 1'b1;
                end
                S_CHK: begin
                    if (w_accept) begin
                        if (i_rx_data == r_chk) r_done <= 1'b1;
                        else                    r_err  <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_mem_addr     = {{(32-CNT_W){1'b0}}, r_mem_addr};
    assign o_mem_wdata    = r_mem_wdata;
    assign o_busy         = (r_state != S_IDLE);
    assign o_cpu_hold     = (r_state != S_IDLE);
    assign o_done         = r_done;
    assign o_err          = r_err;
    assign o_words_loaded = r_words;

endmodule
